// File: rtl/recir_active_ctrl.sv
// Purpose: lock controller producing the `active` select for the 4-lane recirculation block.
// Latency: active/state change on the edge that samples the deciding cycle (no extra pipeline stage).
// Backpressure: none; observes every cycle and cannot stall the lanes.
//
// Ports:
//   clk, reset        - single clock, asynchronous active-high reset
//   in0..in3          - lane bytes from the serial-to-parallel stage
//   valid_in[3:0]     - per-lane valid, bit i qualifies in{i}
//   active            - 1: forward to mux, 0: forward to tester (mirrors state==ACTIVE)
//   state[1:0]        - 0 SEARCH, 1 ALIGN, 2 ACTIVE
//   lock_lost         - one-cycle pulse on each ACTIVE->SEARCH transition
//   align_err         - one-cycle pulse when ALIGN aborts
//   lost_cnt[7:0]     - saturating count of lock_lost events
//
// Optional build macro RECIR_ACTIVE_CTRL_IDLE_EXIT_EN: drops lock after
// IDLE_EXIT_COUNT consecutive all-lane idle cycles. IDL_SYM and
// IDLE_EXIT_COUNT only exist as parameters when the macro is defined.
module recir_active_ctrl #(
  parameter logic [7:0] COM_SYM         = 8'hBC,
`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
  parameter logic [7:0] IDL_SYM         = 8'h7C,
  parameter int         IDLE_EXIT_COUNT = 8,
`endif
  parameter int         LOCK_COUNT      = 4,
  parameter int         LOSS_COUNT      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] valid_in,
  output logic       active,
  output logic [1:0] state,
  output logic       lock_lost,
  output logic       align_err,
  output logic [7:0] lost_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = LOCK_COUNT[3:0];
  localparam logic [3:0] LOSS_CNT = LOSS_COUNT[3:0];

  state_t     state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [3:0] bad_cnt_q, bad_cnt_d;
  logic [7:0] lost_cnt_d;
  logic       lock_lost_d, align_err_d;
  logic       leave_active;

  logic good, all_com;
  assign good    = (valid_in == 4'hF);
  // A partial comma (some lanes COM, some not) is simply !all_com, so no
  // separate any-lane decode is needed to abort ALIGN.
  assign all_com = good && (in0 == COM_SYM) && (in1 == COM_SYM) &&
                   (in2 == COM_SYM) && (in3 == COM_SYM);

`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
  localparam logic [7:0] IDLE_CNT = IDLE_EXIT_COUNT[7:0];
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       all_idl;
  assign all_idl = (in0 == IDL_SYM) && (in1 == IDL_SYM) &&
                   (in2 == IDL_SYM) && (in3 == IDL_SYM);
`endif

  always_comb begin
    state_d      = state_q;
    com_cnt_d    = com_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    lost_cnt_d   = lost_cnt_q_int();
    lock_lost_d  = 1'b0;
    align_err_d  = 1'b0;
    leave_active = 1'b0;
`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
    idle_cnt_d   = idle_cnt_q;
`endif
    case (state_q)
      SEARCH: begin
        com_cnt_d = 4'd0;
        if (all_com) begin
          if (LOCK_COUNT == 1) begin
            state_d = ACTIVE;
          end else begin
            state_d   = ALIGN;
            com_cnt_d = 4'd1;
          end
        end
      end
      ALIGN: begin
        if (all_com) begin
          if (com_cnt_q + 4'd1 == LOCK_CNT) begin
            state_d   = ACTIVE;
            com_cnt_d = 4'd0;
          end else begin
            com_cnt_d = com_cnt_q + 4'd1;
          end
        end else begin
          state_d     = SEARCH;
          com_cnt_d   = 4'd0;
          align_err_d = 1'b1;
        end
      end
      ACTIVE: begin
        // Good cycles win over comma decode: COM is plain data once locked.
        if (good) begin
          bad_cnt_d = 4'd0;
`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
          if (all_idl) begin
            if (idle_cnt_q + 8'd1 == IDLE_CNT) leave_active = 1'b1;
            else                               idle_cnt_d   = idle_cnt_q + 8'd1;
          end else begin
            idle_cnt_d = 8'd0;
          end
`endif
        end else begin
          if (bad_cnt_q + 4'd1 == LOSS_CNT) leave_active = 1'b1;
          else                              bad_cnt_d    = bad_cnt_q + 4'd1;
        end
        // Idle exit and loss share one exit path, so at most one transition
        // and one lost_cnt increment can happen per cycle.
        if (leave_active) begin
          state_d     = SEARCH;
          bad_cnt_d   = 4'd0;
          lock_lost_d = 1'b1;
          if (lost_cnt != 8'hFF) lost_cnt_d = lost_cnt + 8'd1;
`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
          idle_cnt_d  = 8'd0;
`endif
        end
      end
      default: begin
        state_d   = SEARCH;
        com_cnt_d = 4'd0;
        bad_cnt_d = 4'd0;
      end
    endcase
  end

  function automatic logic [7:0] lost_cnt_q_int();
    return lost_cnt;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      com_cnt_q <= 4'd0;
      bad_cnt_q <= 4'd0;
      active    <= 1'b0;
      lock_lost <= 1'b0;
      align_err <= 1'b0;
      lost_cnt  <= 8'd0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      active    <= (state_d == ACTIVE);
      lock_lost <= lock_lost_d;
      align_err <= align_err_d;
      lost_cnt  <= lost_cnt_d;
    end
  end

`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_cnt_q <= 8'd0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_recir_active_ctrl.sv
// Directed bench for recir_active_ctrl: reset, lock, partial-comma abort,
// loss with an intervening good cycle, async reset mid-lock, idle stimulus.
module tb_recir_active_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] valid_in;
  logic       active;
  logic [1:0] state;
  logic       lock_lost;
  logic       align_err;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;

  recir_active_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .valid_in (valid_in),
    .active   (active),
    .state    (state),
    .lock_lost(lock_lost),
    .align_err(align_err),
    .lost_cnt (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input logic [3:0] v);
    in0 = b0; in1 = b1; in2 = b2; in3 = b3; valid_in = v;
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick(); tick();
    checks++;
    if (state !== 2'd0 || active !== 1'b0 || lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d active=%0b lost_cnt=%0d want 0/0/0", state, active, lost_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (state !== 2'd0 || active !== 1'b0 || lock_lost !== 1'b0 ||
          lost_cnt !== 8'd0 || align_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: state=%0d active=%0b lock_lost=%0b lost_cnt=%0d align_err=%0b want all 0",
                 i, state, active, lock_lost, lost_cnt, align_err);
      end
    end
  endtask

  task automatic test_partial_abort();
    logic [1:0] exp_st [3];
    logic       exp_ae [3];
    exp_st = '{2'd1, 2'd1, 2'd0};
    exp_ae = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
      else       drive(8'hBC, 8'hBC, 8'h00, 8'hBC, 4'hF);
      tick();
      checks++;
      if (state !== exp_st[i] || align_err !== exp_ae[i] || active !== 1'b0) begin
        errors++;
        $display("FAIL partial_abort[%0d]: state=%0d align_err=%0b active=%0b want %0d/%0b/0",
                 i, state, align_err, active, exp_st[i], exp_ae[i]);
      end
    end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    checks++;
    if (align_err !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL align_err_pulse: align_err=%0b state=%0d want 0/0", align_err, state);
    end
  endtask

  task automatic test_lock(input string tag);
    logic [1:0] exp_st [4];
    logic       exp_act [4];
    exp_st  = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_act = '{1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL %s_start: state=%0d want 0", tag, state);
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'hBC, 8'hBC, 8'hBC, 8'hBC, 4'hF);
      tick();
      checks++;
      if (state !== exp_st[i] || active !== exp_act[i]) begin
        errors++;
        $display("FAIL %s[%0d]: state=%0d active=%0b want %0d/%0b",
                 tag, i, state, active, exp_st[i], exp_act[i]);
      end
    end
  endtask

  task automatic test_loss();
    logic [3:0] vin     [7];
    logic [1:0] exp_st  [7];
    logic       exp_ll  [7];
    logic [7:0] exp_cnt [7];
    // COM on all lanes while ACTIVE is ordinary good data (first vector).
    vin     = '{4'hF, 4'h7, 4'h7, 4'hF, 4'h7, 4'h7, 4'h7};
    exp_st  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    exp_ll  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_cnt = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 7; i++) begin
      drive(8'hBC, 8'hBC, 8'hBC, 8'hBC, vin[i]);
      tick();
      checks++;
      if (state !== exp_st[i] || lock_lost !== exp_ll[i] || lost_cnt !== exp_cnt[i] ||
          active !== (exp_st[i] == 2'd2)) begin
        errors++;
        $display("FAIL loss[%0d]: state=%0d lock_lost=%0b lost_cnt=%0d active=%0b want %0d/%0b/%0d",
                 i, state, lock_lost, lost_cnt, active, exp_st[i], exp_ll[i], exp_cnt[i]);
      end
    end
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    checks++;
    if (lock_lost !== 1'b0 || lost_cnt !== 8'd1 || state !== 2'd0) begin
      errors++;
      $display("FAIL loss_after: lock_lost=%0b lost_cnt=%0d state=%0d want 0/1/0", lock_lost, lost_cnt, state);
    end
  endtask

  task automatic test_async_reset();
    test_lock("relock_pre");
    checks++;
    if (lost_cnt !== 8'd1) begin
      errors++;
      $display("FAIL lost_cnt_kept: got %0d want 1", lost_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (active !== 1'b0 || state !== 2'd0 || lost_cnt !== 8'd0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: active=%0b state=%0d lost_cnt=%0d lock_lost=%0b want 0/0/0/0",
               active, state, lost_cnt, lock_lost);
    end
    #1;
    reset = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    tick();
    test_lock("relock_post");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 8; i++) begin
      drive(8'h7C, 8'h7C, 8'h7C, 8'h7C, 4'hF);
      tick();
`ifdef RECIR_ACTIVE_CTRL_IDLE_EXIT_EN
      checks++;
      if (i < 7) begin
        if (state !== 2'd2 || lock_lost !== 1'b0) begin
          errors++;
          $display("FAIL idle[%0d]: state=%0d lock_lost=%0b want 2/0", i, state, lock_lost);
        end
      end else if (state !== 2'd0 || lock_lost !== 1'b1 || lost_cnt !== 8'd1 || active !== 1'b0) begin
        errors++;
        $display("FAIL idle_exit: state=%0d lock_lost=%0b lost_cnt=%0d active=%0b want 0/1/1/0",
                 state, lock_lost, lost_cnt, active);
      end
`else
      checks++;
      if (state !== 2'd2 || lock_lost !== 1'b0 || lost_cnt !== 8'd0 || active !== 1'b1) begin
        errors++;
        $display("FAIL idle_data[%0d]: state=%0d lock_lost=%0b lost_cnt=%0d active=%0b want 2/0/0/1",
                 i, state, lock_lost, lost_cnt, active);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_partial_abort();
    test_lock("lock");
    test_loss();
    test_async_reset();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
